// File: rtl/muldiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_pkg : op codes, controller states and decode helpers for muldiv_seq
// Revision   : 1.0
// ----------------------------------------------------------------------------
package muldiv_pkg;

   localparam int c_CNT_W = 7;

   typedef enum logic [3:0] {
      MUL    = 4'd0,
      MULH   = 4'd1,
      MULHSU = 4'd2,
      MULHU  = 4'd3,
      DIV    = 4'd4,
      DIVU   = 4'd5,
      REM    = 4'd6,
      REMU   = 4'd7,
      MULW   = 4'd8,
      DIVW   = 4'd9,
      DIVUW  = 4'd10,
      REMW   = 4'd11,
      REMUW  = 4'd12
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_div(input op_e o);
      return (o inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW});
   endfunction

   function automatic logic is_w(input op_e o);
      return (o inside {MULW, DIVW, DIVUW, REMW, REMUW});
   endfunction

   function automatic logic is_rem(input op_e o);
      return (o inside {REM, REMU, REMW, REMUW});
   endfunction

   // MULW only keeps the low half of the product, so its signedness is moot
   function automatic logic signed_a(input op_e o);
      return (o inside {MUL, MULH, MULHSU, DIV, REM, DIVW, REMW});
   endfunction

   function automatic logic signed_b(input op_e o);
      return (o inside {MUL, MULH, DIV, REM, DIVW, REMW});
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_core : 128-bit shift register doing one unsigned shift-add multiply
//               or restoring-divide step per enable
// Revision    : 1.0
// ----------------------------------------------------------------------------
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = 64
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              en,
   input  logic              is_div,
   input  logic [2*XLEN-1:0] load_acc,
   input  logic [XLEN-1:0]   load_b,
   output logic [2*XLEN-1:0] step
);

   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_b;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN+1:0]   w_diff;

   // Multiply: {hi,lo} holds {partial, multiplier}; divide: {remainder, dividend}
   always_comb begin
      w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
      w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
      w_diff   = {1'b0, w_rem_sh} - {2'b00, r_b};
      if (is_div) begin
         if (w_diff[XLEN+1:XLEN] == 2'b00)
            step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
         else
            step = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end else begin
         step = {w_sum, r_acc[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_b   <= '0;
      end else if (load) begin
         r_acc <= load_acc;
         r_b   <= load_b;
      end else if (en) begin
         r_acc <= step;
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_seq : multi-cycle RV64M multiply/divide sequencer with pipeline stall
// Revision   : 1.0
// ----------------------------------------------------------------------------
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN         = 64,
   parameter int FAST_SPECIAL = 1
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int c_HALF = XLEN / 2;

   state_e               r_state;
   op_e                  r_op;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_busy, r_done, r_neg_q, r_neg_r, r_special;
   logic [XLEN-1:0]      r_result, r_spec_res;

   op_e                  w_op;
   logic                 w_w, w_sa, w_sb, w_div, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_spec;
   logic [XLEN-1:0]      w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_dvd, w_spec_res;
   logic [2*XLEN-1:0]    w_load_acc, w_step, w_prod;
   logic [XLEN-1:0]      w_q, w_r, w_fix;
   logic [c_HALF-1:0]    w_q32, w_r32;
   logic                 w_accept;

   assign w_op     = op_e'(op);
   assign w_accept = (r_state == IDLE) && start && !clear;

   // Operand conditioning at accept: extend, take magnitudes, detect specials
   always_comb begin
      w_w   = is_w(w_op);
      w_sa  = signed_a(w_op);
      w_sb  = signed_b(w_op);
      w_div = is_div(w_op);
      if (w_w) begin
         w_a_ext = w_sa ? {{c_HALF{src1[c_HALF-1]}}, src1[c_HALF-1:0]} : {{c_HALF{1'b0}}, src1[c_HALF-1:0]};
         w_b_ext = w_sb ? {{c_HALF{src2[c_HALF-1]}}, src2[c_HALF-1:0]} : {{c_HALF{1'b0}}, src2[c_HALF-1:0]};
         w_dvd   = {{c_HALF{src1[c_HALF-1]}}, src1[c_HALF-1:0]};
      end else begin
         w_a_ext = src1;
         w_b_ext = src2;
         w_dvd   = src1;
      end
      w_a_neg  = w_sa & w_a_ext[XLEN-1];
      w_b_neg  = w_sb & w_b_ext[XLEN-1];
      w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
      w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
      w_min    = '0;
      w_min[XLEN-1] = 1'b1;
      if (w_w)
         w_min[XLEN-1:c_HALF-1] = '1;
      w_b_zero = (w_b_ext == '0);
      w_ovf    = w_sa && (w_a_ext == w_min) && (w_b_ext == '1);
      w_spec   = w_div && (w_b_zero || w_ovf);
      if (is_rem(w_op))
         w_spec_res = w_b_zero ? w_dvd : '0;
      else
         w_spec_res = w_b_zero ? '1 : w_dvd;
      if (w_div && w_w)
         w_load_acc = {{XLEN{1'b0}}, w_a_mag[c_HALF-1:0], {c_HALF{1'b0}}};
      else
         w_load_acc = {{XLEN{1'b0}}, w_a_mag};
   end

   muldiv_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_accept),
      .en       (r_state == CALC),
      .is_div   (is_div(r_op)),
      .load_acc (w_load_acc),
      .load_b   (w_b_mag),
      .step     (w_step)
   );

   // Sign fix-up applied to the value produced by the final iteration
   always_comb begin
      w_prod = r_neg_q ? -w_step : w_step;
      w_q    = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
      w_r    = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
      w_q32  = r_neg_q ? -w_step[c_HALF-1:0] : w_step[c_HALF-1:0];
      w_r32  = r_neg_r ? -w_step[XLEN+c_HALF-1:XLEN] : w_step[XLEN+c_HALF-1:XLEN];
      case (r_op)
         MUL:                 w_fix = w_prod[XLEN-1:0];
         MULH, MULHSU, MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
         MULW:                w_fix = {{c_HALF{w_step[XLEN-1]}}, w_step[XLEN-1:c_HALF]};
         DIV, DIVU:           w_fix = w_q;
         REM, REMU:           w_fix = w_r;
         DIVW, DIVUW:         w_fix = {{c_HALF{w_q32[c_HALF-1]}}, w_q32};
         default:             w_fix = {{c_HALF{w_r32[c_HALF-1]}}, w_r32};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_op       <= MUL;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_special  <= 1'b0;
         r_spec_res <= '0;
         r_result   <= '0;
      end else if (clear) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op       <= w_op;
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_special  <= w_spec;
                  r_spec_res <= w_spec_res;
                  r_cnt      <= w_w ? 7'd32 : 7'd64;
                  if ((FAST_SPECIAL != 0) && w_spec) begin
                     r_state  <= DONE;
                     r_done   <= 1'b1;
                     r_result <= w_spec_res;
                  end else begin
                     r_state <= CALC;
                     r_busy  <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_cnt <= r_cnt - 7'd1;
               if (r_cnt == 7'd1) begin
                  r_state  <= DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_result <= r_special ? r_spec_res : w_fix;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stall_req = w_accept || (r_state == CALC);
   assign busy      = r_busy;
   assign done      = r_done & ~clear;
   assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_seq : directed-vector bench for muldiv_seq
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_seq;

   localparam logic [3:0] c_MUL = 4'd0, c_MULH = 4'd1, c_MULHSU = 4'd2, c_MULHU = 4'd3;
   localparam logic [3:0] c_DIV = 4'd4, c_DIVU = 4'd5, c_REM = 4'd6, c_REMU = 4'd7;
   localparam logic [3:0] c_MULW = 4'd8, c_DIVW = 4'd9, c_DIVUW = 4'd10, c_REMW = 4'd11, c_REMUW = 4'd12;
   localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] c_MIN  = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst_n, clear, start;
   logic [3:0]  op;
   logic [63:0] src1, src2;
   logic        stall_req, busy, done;
   logic [63:0] result;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] last_res = '0;
   logic        seen;

   always #5 clk = ~clk;

   muldiv_seq #(.XLEN(64), .FAST_SPECIAL(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .start     (start),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .stall_req (stall_req),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, then measure latency, stall length, result and pulse width
   task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      int stalls;
      @(negedge clk);
      op = o; src1 = a; src2 = b; start = 1'b1;
      #1;
      stalls = int'(stall_req);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 200) begin
         stalls += int'(stall_req);
         @(negedge clk);
         lat++;
      end
      check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, " result"}, result, exp_res);
      check_eq({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
      check_eq({tag, " stall in done"}, {63'b0, stall_req}, 64'd0);
      @(negedge clk);
      check_eq({tag, " done width"}, {63'b0, done}, 64'd0);
      last_res = exp_res;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; start = 1'b0; op = '0; src1 = '0; src2 = '0;
      repeat (3) @(negedge clk);
      check_eq("reset busy", {63'b0, busy}, 64'd0);
      check_eq("reset done", {63'b0, done}, 64'd0);
      check_eq("reset result", result, 64'd0);
      check_eq("reset stall", {63'b0, stall_req}, 64'd0);
      rst_n = 1'b1;

      run_op("mul 7*-3",     c_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      run_op("mulhu ones",   c_MULHU,  c_ONES, c_ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run_op("mulh ones",    c_MULH,   c_ONES, c_ONES, 64'd0, 65);
      run_op("mulh -2*3",    c_MULH,   64'hFFFF_FFFF_FFFF_FFFE, 64'd3, c_ONES, 65);
      run_op("mulhsu -1*2",  c_MULHSU, c_ONES, 64'd2, c_ONES, 65);
      run_op("mulhu 2^63*4", c_MULHU,  c_MIN, 64'd4, 64'd2, 65);
      run_op("div ovf",      c_DIV,    c_MIN, c_ONES, c_MIN, 1);
      run_op("rem ovf",      c_REM,    c_MIN, c_ONES, 64'd0, 1);
      run_op("divu by 0",    c_DIVU,   64'd100, 64'd0, c_ONES, 1);
      run_op("remu by 0",    c_REMU,   64'd100, 64'd0, 64'd100, 1);
      run_op("remw by 0",    c_REMW,   64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);
      run_op("divw -20/3",   c_DIVW,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33);
      run_op("remw -20/3",   c_REMW,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      run_op("div -100/7",   c_DIV,    64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
      run_op("rem 100/-7",   c_REM,    64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
      run_op("divu big/16",  c_DIVU,   c_ONES, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65);
      run_op("divuw",        c_DIVUW,  64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
      run_op("remuw",        c_REMUW,  64'h0000_0000_FFFF_FFF7, 64'd16, 64'd7, 33);
      run_op("mulw wrap",    c_MULW,   64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);

      // Flush an in-flight divide at cycle 10 after accept
      @(negedge clk);
      op = c_DIVU; src1 = 64'd1000; src2 = 64'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_eq("clear stall", {63'b0, stall_req}, 64'd0);
      check_eq("clear busy", {63'b0, busy}, 64'd0);
      check_eq("clear done", {63'b0, done}, 64'd0);
      check_eq("clear result", result, last_res);
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check_eq("clear no done", {63'b0, seen}, 64'd0);
      run_op("mulw 3*5", c_MULW, 64'd3, 64'd5, 64'd15, 33);

      // Reset in the middle of an iteration
      @(negedge clk);
      op = c_DIVU; src1 = 64'd1000; src2 = 64'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("pre-reset busy", {63'b0, busy}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("mid reset busy", {63'b0, busy}, 64'd0);
      check_eq("mid reset done", {63'b0, done}, 64'd0);
      check_eq("mid reset result", result, 64'd0);
      check_eq("mid reset stall", {63'b0, stall_req}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle RV64M multiply/divide sequencer attached to the execute stage beside the single-cycle ALU.
- Accepts one M-extension operation from execute and asserts a stall request so that execute, the EX/MA register and upstream stages hold.
- Iterates a radix-2 shift-add / restoring-divide datapath, then presents a one-cycle `done` with the result for execute to pass into EX/MA as `result`.
- Is aborted by pipeline `clear`, for example on a trap or redirect.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle instead of the full iteration count.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clear  in  1  pipeline flush; aborts any operation in flight
start  in  1  operation request from execute, qualified by a valid M op
op  in  4  operation code (see Decomposition)
src1  in  64  operand a (forwarded rs1)
src2  in  64  operand b (forwarded rs2)
stall_req  out  1  hold the pipeline; combinational
busy  out  1  registered; high in CALC
done  out  1  one-cycle result-valid pulse
result  out  64  final result; held until the next accepted start

Behaviour:
- Reset: rst_n is sampled on posedge clk.
  - state=IDLE, busy=0, done=0, result=0, cnt=0, internal accumulators=0.
- States: IDLE, CALC, DONE.
- IDLE with start=1 and clear=0 (accept):
  - Latch op.
  - Latch |a| and |b| for signed operands, and the operand signs.
  - Set cnt to 64, or to 32 for W ops.
  - Go to CALC.
  - If FAST_SPECIAL and the op is a divide/remainder with a special case (b==0, or signed overflow), go directly to DONE instead.
- CALC:
  - One iteration per cycle; cnt decrements.
  - When cnt reaches 1, go to DONE on the next edge.
  - Latency from the accept edge to the `done` cycle: 65 cycles for 64-bit ops, 33 cycles for W ops, 1 cycle for the special fast path.
- DONE:
  - done=1 for exactly one cycle.
  - result is registered and the sign fix-up is applied.
  - Next state is IDLE.
  - A start seen in the DONE cycle is ignored. Execute only issues the next op after the pipeline advances.
- stall_req = (state==IDLE & start & ~clear) | (state==CALC). It is low in DONE, so the pipeline advances on the cycle `done` is high.
- start while in CALC or DONE: ignored; no re-latch.
- clear has priority in every state:
  - Next state is IDLE.
  - The done pulse is suppressed. If clear coincides with DONE, done is still forced to 0.
  - result keeps its last value.
- Arithmetic:
  - MUL returns the low 64 bits of the product.
  - MULH, MULHSU and MULHU return the high 64 bits of the 128-bit product, with operand signedness as in the ISA. For MULHSU only src1 is signed.
  - Signed results: compute on magnitudes, then negate the 128-bit product or quotient when the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (all div/rem variants):
  - Quotient = all ones.
  - Remainder = dividend, which for W ops is the sign-extended low 32 bits of src1.
- Signed overflow:
  - DIV with -2^63 / -1 gives quotient -2^63 and remainder 0.
  - DIVW with -2^31 / -1 gives quotient sext(-2^31) and remainder 0.
- W ops: operands are the low 32 bits, sign- or zero-extended per op, and the 32-bit result is sign-extended to 64.
- Iteration counter: 7 bits. No wrap, because cnt is only loaded on accept.

Decomposition:
- Shared package `muldiv_pkg`:
  - op enum: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7, MULW=8, DIVW=9, DIVUW=10, REMW=11, REMUW=12.
  - state enum.
  - Helper functions is_div, is_w and signed_a / signed_b.
- One sub-module `muldiv_core`: a 128-bit shift register with an adder/subtractor that performs one mul or div step per enable. The controller FSM and sign handling stay in muldiv_seq.

Test Plan:
1. MUL, src1=7, src2=-3 (0xFFFF...FFFD), start for 1 cycle:
   - stall_req high for 65 cycles.
   - done on cycle 65 with result=0xFFFF_FFFF_FFFF_FFEB.
   - stall_req=0 in the done cycle.
2. MULHU with src1=src2=0xFFFF_FFFF_FFFF_FFFF gives 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands gives 0.
3. DIV with -2^63 / -1 gives 0x8000_0000_0000_0000. REM with the same operands gives 0. With FAST_SPECIAL=1, done arrives 1 cycle after accept.
4. DIVU 100/0 gives 0xFFFF_FFFF_FFFF_FFFF. REMU 100/0 gives 100. REMW with src1=0x1_8000_0005 and src2=0 gives 0xFFFF_FFFF_8000_0005.
5. DIVW with src1=-20 and src2=3:
   - done on cycle 33.
   - result=0xFFFF_FFFF_FFFF_FFFA (-6).
   - REMW with the same operands gives -2.
6. Start DIVU, assert clear at cycle 10:
   - Next cycle: IDLE, stall_req=0, no done pulse, result unchanged.
   - A new MULW 3*5 accepted afterwards returns 15 after 33 cycles.
   - rst_n=0 mid-CALC gives all outputs 0 on the next edge.
